// File: rtl/io_pattern_gen_if.sv
// IO-ring bundle between the FABulous IO_1_bidirectional cells and the
// io_pattern_gen bring-up design.
//   io_in  : pad values from the IO cells (cell O)
//   io_out : values driven to the IO cells (cell I)
//   io_oeb : per-pin output enable, active-low (cell T); 1 = input
// master : pad/cell side (drives io_in, observes io_out/io_oeb)
// slave  : design side (reads io_in, drives io_out/io_oeb)
interface io_pattern_gen_if;
  logic [30:0] io_in;
  logic [30:0] io_out;
  logic [30:0] io_oeb;

  modport master (output io_in, input io_out, input io_oeb);
  modport slave (input io_in, output io_out, output io_oeb);
endinterface

// File: rtl/io_pattern_gen.sv
// Bring-up pattern generator for the FABulous fabric test wrapper.
// Pin-selected modes exercise the IO ring and fabric clocking:
//   mode 0 counter, 1 walking one, 2 LFSR (taps 27,5,2,1), 3 loopback.
// Pin map: io[30:29] mode (in), io[28] run (in), io[27] status (out),
//          io[26:0] pattern bus (io[26:14] become inputs in loopback).
// Ports:
//   clk : fabric global clock
//   rst : asynchronous, active-high reset
//   io  : io_pattern_gen_if.slave (io_in, io_out, io_oeb)
// Parameter DIV: pattern advances once every DIV run-high cycles (DIV >= 1).
// Optional macro IO_PATTERN_PARITY_EN: io_out[27] = XOR of the pattern;
// otherwise io_out[27] is tied to 0.
module io_pattern_gen #(
  parameter int unsigned DIV = 16
) (
  input logic             clk,
  input logic             rst,
  io_pattern_gen_if.slave io
);

  localparam int unsigned PrescW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(DIV - 1);

  typedef enum logic [1:0] {
    ModeCount = 2'd0,
    ModeWalk  = 2'd1,
    ModeLfsr  = 2'd2,
    ModeLoop  = 2'd3
  } mode_e;

  logic [1:0]        m1_q, m2_q;
  logic              r1_q, r2_q;
  logic [12:0]       lb1_q;
  mode_e             active_mode_q, active_mode_d;
  logic [26:0]       pat_q, pat_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick;
  logic              lfsr_fb;

  logic unused_in;
  assign unused_in = ^{io.io_in[27], io.io_in[13:0]};

  assign tick    = r2_q && (presc_q == PrescMax);
  assign lfsr_fb = pat_q[26] ^ pat_q[4] ^ pat_q[1] ^ pat_q[0];

  always_comb begin
    active_mode_d = active_mode_q;
    pat_d         = pat_q;
    presc_d       = presc_q;
    if (mode_e'(m2_q) != active_mode_q) begin
      // Mode change wins over a same-edge tick: reseed and restart the interval.
      active_mode_d = mode_e'(m2_q);
      presc_d       = '0;
      case (mode_e'(m2_q))
        ModeWalk, ModeLfsr: pat_d = 27'd1;
        default:            pat_d = '0;
      endcase
    end else begin
      if (!r2_q || tick) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PrescW'(1);
      end
      unique case (active_mode_q)
        ModeCount: if (tick) pat_d = pat_q + 27'd1;
        ModeWalk:  if (tick) pat_d = {pat_q[25:0], pat_q[26]};
        ModeLfsr:  if (tick) pat_d = {pat_q[25:0], lfsr_fb};
        ModeLoop:  pat_d = {14'd0, lb1_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_q          <= '0;
      m2_q          <= '0;
      r1_q          <= 1'b0;
      r2_q          <= 1'b0;
      lb1_q         <= '0;
      active_mode_q <= ModeCount;
      pat_q         <= '0;
      presc_q       <= '0;
    end else begin
      m1_q          <= io.io_in[30:29];
      m2_q          <= m1_q;
      r1_q          <= io.io_in[28];
      r2_q          <= r1_q;
      lb1_q         <= io.io_in[26:14];
      active_mode_q <= active_mode_d;
      pat_q         <= pat_d;
      presc_q       <= presc_d;
    end
  end

  assign io.io_out[30:28] = 3'b000;
`ifdef IO_PATTERN_PARITY_EN
  assign io.io_out[27]    = ^pat_q;
`else
  assign io.io_out[27]    = 1'b0;
`endif
  assign io.io_out[26:0]  = pat_q;

  assign io.io_oeb[30:28] = 3'b111;
  assign io.io_oeb[27]    = 1'b0;
  // Loopback turns the upper pattern pins around into inputs.
  assign io.io_oeb[26:14] = (active_mode_q == ModeLoop) ? 13'h1fff : 13'h0000;
  assign io.io_oeb[13:0]  = 14'h0000;

endmodule

// File: tb/tb_io_pattern_gen.sv
module tb_io_pattern_gen;

  localparam int unsigned NDut   = 2;
  localparam int unsigned Mask27 = 32'h07ff_ffff;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [30:0] pins = '0;
  int          total = 0;
  int          bad   = 0;

  bit rand_lb   = 1'b1;
  bit rand_run  = 1'b0;
  bit rand_mode = 1'b0;

  io_pattern_gen_if io4 ();
  io_pattern_gen_if io1 ();
  assign io4.io_in = pins;
  assign io1.io_in = pins;

  io_pattern_gen #(.DIV(4)) u_div4 (.clk(clk), .rst(rst), .io(io4));
  io_pattern_gen #(.DIV(1)) u_div1 (.clk(clk), .rst(rst), .io(io1));

  always #5 clk = ~clk;

  // Reference model: pin history queues stand in for the synchronisers,
  // patterns are computed from tick counts since the last reseed.
  int unsigned divs [NDut] = '{4, 1};
  logic [1:0]  mode_hist[$];
  bit          run_hist[$];
  logic [12:0] lb_hist[$];
  int unsigned m_mode;
  int unsigned m_pat [NDut];
  int unsigned m_cnt [NDut];
  int unsigned m_k   [NDut];

  function automatic int unsigned lfsr_next(int unsigned v);
    int unsigned fb;
    fb = ((v >> 26) ^ (v >> 4) ^ (v >> 1) ^ v) & 32'd1;
    return ((v << 1) & Mask27) | fb;
  endfunction

  task automatic model_reset();
    mode_hist = '{2'd0, 2'd0};
    run_hist  = '{1'b0, 1'b0};
    lb_hist   = '{13'd0};
    m_mode    = 0;
    for (int i = 0; i < NDut; i++) begin
      m_pat[i] = 0;
      m_cnt[i] = 0;
      m_k[i]   = 0;
    end
  endtask

  task automatic model_edge();
    int unsigned sm, sl;
    bit          sr, chg;
    mode_hist.push_back(pins[30:29]);
    run_hist.push_back(pins[28]);
    lb_hist.push_back(pins[26:14]);
    sm  = int'(mode_hist.pop_front());
    sr  = run_hist.pop_front();
    sl  = int'(lb_hist.pop_front());
    chg = (sm != m_mode);
    if (chg) m_mode = sm;
    for (int i = 0; i < NDut; i++) begin
      if (chg) begin
        m_k[i]   = 0;
        m_cnt[i] = 0;
        m_pat[i] = (sm == 1 || sm == 2) ? 1 : 0;
      end else if (m_mode == 3) begin
        m_pat[i] = sl;
      end else if (!sr) begin
        m_cnt[i] = 0;
      end else begin
        m_cnt[i]++;
        if (m_cnt[i] == divs[i]) begin
          m_cnt[i] = 0;
          m_k[i]++;
          case (m_mode)
            0:       m_pat[i] = m_k[i] & Mask27;
            1:       m_pat[i] = 32'd1 << (m_k[i] % 27);
            default: m_pat[i] = lfsr_next(m_pat[i]);
          endcase
        end
      end
    end
  endtask

  function automatic logic [30:0] exp_out(int i);
    logic [30:0] e;
    e = 31'(m_pat[i] & Mask27);
`ifdef IO_PATTERN_PARITY_EN
    e[27] = ($countones(m_pat[i]) % 2) == 1;
`endif
    return e;
  endfunction

  function automatic logic [30:0] exp_oeb();
    return (m_mode == 3) ? 31'h77ff_c000 : 31'h7000_0000;
  endfunction

  task automatic check(string tag, logic [30:0] got, logic [30:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic check_all();
    check("out_div4", io4.io_out, exp_out(0));
    check("oeb_div4", io4.io_oeb, exp_oeb());
    check("out_div1", io1.io_out, exp_out(1));
    check("oeb_div1", io1.io_oeb, exp_oeb());
  endtask

  task automatic cycle(int unsigned n);
    for (int unsigned c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      model_edge();
      check_all();
      if (rand_lb) pins[27:0] = 28'($urandom);
      if (rand_run) pins[28] = 1'($urandom);
      if (rand_mode && $urandom_range(0, 7) == 0) pins[30:29] = 2'($urandom);
    end
  endtask

  initial begin
    logic zero_seen;
    zero_seen = 1'b0;

    // Reset with mode 0 / run 1 on the pins.
    pins[30:28] = 3'b001;
    pins[27:0]  = 28'($urandom);
    model_reset();
    #12;
    check("rst_out", io4.io_out, 31'h0);
    check("rst_oeb", io4.io_oeb, 31'h7000_0000);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Counter, DIV=4 steps 1,2,3 at edges 6,10,14 after release.
    cycle(14);
    check("cnt_step3", {4'd0, io4.io_out[26:0]}, 31'd3);
    cycle(26);

    // Walking one, DIV=1.
    pins[30:29] = 2'd1;
    cycle(3);
    check("walk_seed", {4'd0, io1.io_out[26:0]}, 31'h1);
    cycle(26);
    check("walk_top", {4'd0, io1.io_out[26:0]}, 31'h400_0000);
    cycle(1);
    check("walk_wrap", {4'd0, io1.io_out[26:0]}, 31'h1);

    // LFSR.
    pins[30:29] = 2'd2;
    cycle(3);
    check("lfsr_0", {4'd0, io1.io_out[26:0]}, 31'h1);
    cycle(1);
    check("lfsr_1", {4'd0, io1.io_out[26:0]}, 31'h3);
    cycle(1);
    check("lfsr_2", {4'd0, io1.io_out[26:0]}, 31'h6);
    cycle(1);
    check("lfsr_3", {4'd0, io1.io_out[26:0]}, 31'hd);
    for (int i = 0; i < 10000; i++) begin
      cycle(1);
      if (io1.io_out[26:0] == 27'd0 || io4.io_out[26:0] == 27'd0) zero_seen = 1'b1;
    end
    check("lfsr_nonzero", {30'd0, zero_seen}, 31'd0);

    // Loopback: run ignored, 2-edge latency from io_in[26:14].
    rand_lb      = 1'b0;
    pins[30:29]  = 2'd3;
    pins[28]     = 1'b0;
    pins[26:14]  = 13'h1555;
    cycle(3);
    check("loop_oeb", io1.io_oeb, 31'h77ff_c000);
    cycle(1);
    check("loop_1555", {4'd0, io4.io_out[26:0]}, 31'h1555);
    pins[26:14] = 13'h0aaa;
    cycle(1);
    check("loop_lat1", {4'd0, io1.io_out[26:0]}, 31'h1555);
    cycle(1);
    check("loop_lat2", {4'd0, io1.io_out[26:0]}, 31'h0aaa);
    rand_lb  = 1'b1;
    rand_run = 1'b1;
    cycle(50);

    // Counter, run drop, then asynchronous reset mid-interval.
    rand_run    = 1'b0;
    pins[30:28] = 3'b001;
    cycle(23);
    pins[28] = 1'b0;
    cycle(10);
    pins[28] = 1'b1;
    cycle(5);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async", io4.io_out, 31'h0);
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(20);
    check("restart_cnt", {4'd0, io4.io_out[26:0]}, 31'd4);

    // Random mode/run changes to hit mode-change vs tick collisions.
    rand_run  = 1'b1;
    rand_mode = 1'b1;
    cycle(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
